fifo_rr_arbiter: RTL and testbench
==================================

FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 Parameter NUM_CHN, default 4: number of requester FIFOs, range 2..8.
REQ-002 Parameter DATA_WIDTH, default 16: word width of every channel.
REQ-003 Parameter BURST_LEN, default 4: maximum words per grant, range 1..256.
REQ-004 Port clk, input, 1: clock; all logic on the positive edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-high.
REQ-006 Port chn_nempty, input, NUM_CHN: per-channel FIFO "has data" flag.
REQ-007 Port chn_half_full, input, NUM_CHN: per-channel FIFO "half full" flag.
REQ-008 Port chn_data, input, NUM_CHN*DATA_WIDTH: per-channel FIFO head word; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port chn_re, output, NUM_CHN: per-channel FIFO read (pop) strobe.
REQ-010 Port dout, output, DATA_WIDTH: head word of the granted channel.
REQ-011 Port dout_chn, output, clog2(NUM_CHN): index of the granted channel.
REQ-012 Port dout_valid, output, 1: dout holds a valid word.
REQ-013 Port dout_ready, input, 1: downstream accepts dout this cycle.
REQ-014 Port dout_last, output, 1: current word is the final word of a full-length burst.
REQ-015 Port busy, output, 1: a grant is active.

Function
REQ-016 The FSM SHALL have two states: IDLE and GRANT.
REQ-017 In IDLE with any chn_nempty set, the block SHALL register grant = first requesting channel searching upward (mod NUM_CHN) from last_chn+1, clear burst count, and enter GRANT on the next edge.
REQ-018 In IDLE with no requests, the block SHALL remain in IDLE with busy=0, dout_valid=0 and chn_re all 0.
REQ-019 In GRANT, dout_valid SHALL equal chn_nempty[grant] combinationally; dout SHALL equal chn_data of grant, and dout_chn SHALL equal grant.
REQ-020 chn_re[grant] SHALL equal dout_valid AND dout_ready (one transfer); all other chn_re bits SHALL be 0; pop latency is zero cycles.
REQ-021 Each transfer SHALL increment the burst count (width clog2(BURST_LEN)+1).
REQ-022 dout_last SHALL be 1 exactly when dout_valid=1 and count = BURST_LEN-1.
REQ-023 A transfer with dout_last=1 SHALL set last_chn=grant and return to IDLE on the next edge.
REQ-024 If chn_nempty[grant]=0 while in GRANT (FIFO drained mid-burst), the block SHALL set last_chn=grant and return to IDLE next edge; the burst is truncated without dout_last.
REQ-025 dout_ready=0 SHALL hold state, count and dout; no timeout applies.
REQ-026 IDLE-to-GRANT SHALL cost exactly one dead cycle; back-to-back bursts therefore have one gap cycle.
REQ-027 A channel that is granted and has data SHALL NOT be pre-empted before its burst ends.

Reset
REQ-028 While rst=1: state=IDLE, grant=0, count=0, last_chn=NUM_CHN-1 (channel 0 wins the first arbitration), busy=0, dout_valid=0, dout_last=0, chn_re=0.
REQ-029 rst asserted mid-burst SHALL abort immediately with no further chn_re pulse; the words already popped are not restored.

Configuration
REQ-030 With FIFO_RR_ARBITER_URGENT_EN defined, IDLE arbitration SHALL consider only channels with chn_nempty AND chn_half_full if any exist, using round-robin among them; otherwise it SHALL fall back to plain round-robin.
REQ-031 Without FIFO_RR_ARBITER_URGENT_EN, chn_half_full SHALL be ignored (unused), and the block is pure round-robin.

Structure
REQ-032 The FSM state encoding and the clog2 helper function SHALL live in shared package fifo_arb_pkg.
REQ-033 The round-robin search SHALL be a separate combinational sub-module, rr_pick (inputs: request vector, last index; outputs: found, index), instantiated once; the urgent mask is applied before it.

Verification
REQ-034 Channel 2 alone holds 6 words, dout_ready=1 -> 4 pops with dout_last on the 4th, 1 idle cycle, then 2 pops and a truncated return to IDLE.
REQ-035 All 4 channels hold 8 words each, dout_ready=1 -> grant order 0,1,2,3,0,1,2,3; 8 bursts of 4 words.
REQ-036 Granted channel 1, dout_ready toggles 1,0,0,1 -> chn_re[1] pulses only when ready=1; dout is stable while ready=0.
REQ-037 rst pulsed after the 2nd word of a burst on channel 3 -> chn_re=0 during reset, and the next grant goes to channel 0.
REQ-038 With FIFO_RR_ARBITER_URGENT_EN, channels 0 and 2 nempty, channel 2 half_full, last_chn=3 -> channel 2 is granted first; without the macro, channel 0 is granted first.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// +----------------------------------------------------------------------------+
// | fifo_arb_pkg : shared FSM state encoding and clog2 helper for the arbiter  |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// +----------------------------------------------------------------------------+
// | rr_pick : combinational round-robin search upward from last_i+1            |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_pick #(
  parameter int NUM_CHN = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_CHN-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  int               cand;
  logic [IDX_W-1:0] w_cand_idx;
  logic             w_hit;

  always_comb begin
    cand       = 0;
    w_cand_idx = '0;
    w_hit      = 1'b0;
    idx_o      = '0;
    // k = NUM_CHN wraps back to last_i itself, so it is checked last
    for (int k = 1; k <= NUM_CHN; k++) begin
      cand       = (int'(last_i) + k) % NUM_CHN;
      w_cand_idx = IDX_W'(cand);
      if (!w_hit && req_i[w_cand_idx]) begin
        w_hit = 1'b1;
        idx_o = w_cand_idx;
      end
    end
    found_o = w_hit;
  end

endmodule

`default_nettype wire

// File: rtl/fifo_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | fifo_rr_arbiter : round-robin burst arbiter draining NUM_CHN FIFOs         |
// | Option macro FIFO_RR_ARBITER_URGENT_EN: prefer half-full channels.         |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_CHN    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CHN-1:0]            chn_nempty,
  input  logic [NUM_CHN-1:0]            chn_half_full,
  input  logic [NUM_CHN*DATA_WIDTH-1:0] chn_data,
  output logic [NUM_CHN-1:0]            chn_re,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic [clog2(NUM_CHN)-1:0]     dout_chn,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          dout_last,
  output logic                          busy
);

  localparam int c_idx_w = clog2(NUM_CHN);
  localparam int c_cnt_w = clog2(BURST_LEN) + 1;

  arb_state_e           state_q, state_d;
  logic [c_idx_w-1:0]   grant_q, grant_d;
  logic [c_idx_w-1:0]   last_q, last_d;
  logic [c_cnt_w-1:0]   count_q, count_d;

  logic [NUM_CHN-1:0]   w_req;
  logic                 w_pick_found;
  logic [c_idx_w-1:0]   w_pick_idx;
  logic                 w_valid;
  logic                 w_xfer;
  logic                 w_last;

`ifdef FIFO_RR_ARBITER_URGENT_EN
  logic [NUM_CHN-1:0]   w_urgent;
  assign w_urgent = chn_nempty & chn_half_full;
  assign w_req    = (|w_urgent) ? w_urgent : chn_nempty;
`else
  logic                 w_unused_half_full;
  assign w_unused_half_full = ^chn_half_full;
  assign w_req              = chn_nempty;
`endif

  rr_pick #(
    .NUM_CHN (NUM_CHN),
    .IDX_W   (c_idx_w)
  ) u_rr_pick (
    .req_i   (w_req),
    .last_i  (last_q),
    .found_o (w_pick_found),
    .idx_o   (w_pick_idx)
  );

  assign w_valid = (state_q == ST_GRANT) && chn_nempty[grant_q];
  assign w_xfer  = w_valid && dout_ready;
  assign w_last  = w_valid && (count_q == c_cnt_w'(BURST_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= c_idx_w'(NUM_CHN - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (w_pick_found) begin
          grant_d = w_pick_idx;
          count_d = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A drained FIFO ends the burst early, without dout_last
        if (!chn_nempty[grant_q]) begin
          last_d  = grant_q;
          state_d = ST_IDLE;
        end else if (w_xfer) begin
          if (w_last) begin
            last_d  = grant_q;
            state_d = ST_IDLE;
          end else begin
            count_d = count_q + c_cnt_w'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    chn_re          = '0;
    chn_re[grant_q] = w_xfer;
    dout            = chn_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
    dout_chn        = grant_q;
    dout_valid      = w_valid;
    dout_last       = w_last;
    busy            = (state_q == ST_GRANT);
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_fifo_rr_arbiter : randomized scoreboard bench for fifo_rr_arbiter       |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_rr_arbiter;

  localparam int NCH  = 4;
  localparam int DW   = 16;
  localparam int BL   = 4;
  localparam int HALF = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    chn_nempty = '0;
  logic [NCH-1:0]    chn_half_full = '0;
  logic [NCH*DW-1:0] chn_data = '0;
  logic [NCH-1:0]    chn_re;
  logic [DW-1:0]     dout;
  logic [1:0]        dout_chn;
  logic              dout_valid;
  logic              dout_ready = 1'b0;
  logic              dout_last;
  logic              busy;

  fifo_rr_arbiter #(
    .NUM_CHN    (NCH),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .chn_nempty    (chn_nempty),
    .chn_half_full (chn_half_full),
    .chn_data      (chn_data),
    .chn_re        (chn_re),
    .dout          (dout),
    .dout_chn      (dout_chn),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .dout_last     (dout_last),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [DW-1:0] data;
    bit          last;
  } exp_t;

  logic [DW-1:0] fifo [NCH][$];
  exp_t          exp_q[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_fail = 0;
  int            xfer_cnt = 0;
  int            model_last = NCH - 1;
  int            ready_mode = 0;
  int            cyc = 0;
  logic [NCH-1:0] re_smp = '0;
  logic [NCH-1:0] exp_re;
  logic          prev_end = 1'b0;
  logic          prev_idle_req = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_dout = '0;
  logic [1:0]    prev_chn = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: samples 3 time units after the falling edge, pops the scoreboard
  always @(negedge clk) begin
    #3;
    if (rst) begin
      chk("rst_chn_re", chn_re, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", dout_valid, 0);
      chk("rst_last", dout_last, 0);
      chk("rst_dout_chn", dout_chn, 0);
      re_smp        = '0;
      prev_end      = 1'b0;
      prev_idle_req = 1'b0;
      prev_stall    = 1'b0;
    end else begin
      exp_re = '0;
      if (dout_valid && dout_ready) exp_re[dout_chn] = 1'b1;
      chk("chn_re", chn_re, exp_re);
      if (busy) chk("valid", dout_valid, chn_nempty[dout_chn]);
      else      chk("idle_valid", dout_valid, 0);
      if (!dout_valid) chk("last_no_valid", dout_last, 0);
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("xfer_chn", dout_chn, mon_e.ch);
          chk("xfer_data", dout, mon_e.data);
          chk("xfer_last", dout_last, mon_e.last);
        end
        xfer_cnt++;
      end
      if (prev_end)      chk("gap_cycle", busy, 0);
      if (prev_idle_req) chk("idle_to_grant", busy, 1);
      if (prev_stall) begin
        chk("stall_busy", busy, 1);
        chk("stall_dout", dout, prev_dout);
        chk("stall_chn", dout_chn, prev_chn);
      end
      prev_end      = busy && (!dout_valid || (dout_ready && dout_last));
      prev_idle_req = !busy && (|chn_nempty);
      prev_stall    = busy && dout_valid && !dout_ready;
      prev_dout     = dout;
      prev_chn      = dout_chn;
      re_smp        = chn_re;
    end
  end

  task automatic drive();
    for (int c = 0; c < NCH; c++) begin
      chn_nempty[c]        = (fifo[c].size() > 0);
      chn_half_full[c]     = (fifo[c].size() >= HALF);
      chn_data[c*DW +: DW] = (fifo[c].size() > 0) ? fifo[c][0] : '0;
    end
    case (ready_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = ($urandom_range(0, 3) != 0);
      default: dout_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    endcase
  endtask

  // One cycle: retire last cycle's pops, set reset, present new FIFO heads
  task automatic step(input logic rst_v);
    @(negedge clk);
    cyc++;
    for (int c = 0; c < NCH; c++)
      if (re_smp[c] && fifo[c].size() > 0) void'(fifo[c].pop_front());
    rst = rst_v;
    drive();
    #4;
  endtask

  task automatic load(input int c, input int n);
    logic [1:0] tag;
    tag = 2'(c);
    for (int i = 0; i < n; i++) fifo[c].push_back({tag, 14'($urandom)});
  endtask

  // Reference: bursts of min(BL, remaining) words, next channel chosen
  // round-robin after the previous one; no new data arrives during a phase.
  task automatic build_expect();
    int  ptr[NCH];
    int  last;
    int  pick;
    int  rem;
    int  n;
    bit  done;
    for (int c = 0; c < NCH; c++) ptr[c] = 0;
    last = model_last;
    done = 0;
    while (!done) begin
      pick = -1;
`ifdef FIFO_RR_ARBITER_URGENT_EN
      for (int k = 1; k <= NCH; k++) begin
        rem = fifo[(last + k) % NCH].size() - ptr[(last + k) % NCH];
        if (pick < 0 && rem >= HALF) pick = (last + k) % NCH;
      end
`endif
      for (int k = 1; k <= NCH; k++) begin
        rem = fifo[(last + k) % NCH].size() - ptr[(last + k) % NCH];
        if (pick < 0 && rem > 0) pick = (last + k) % NCH;
      end
      if (pick < 0) begin
        done = 1;
      end else begin
        rem = fifo[pick].size() - ptr[pick];
        n   = (rem < BL) ? rem : BL;
        for (int i = 0; i < n; i++)
          exp_q.push_back('{ch: pick, data: fifo[pick][ptr[pick] + i], last: (i == BL - 1)});
        ptr[pick] += n;
        last = pick;
      end
    end
    model_last = last;
  endtask

  task automatic run_phase(input int bound);
    int n;
    n = 0;
    build_expect();
    while ((exp_q.size() != 0 || busy) && n < bound) begin
      step(1'b0);
      n++;
    end
    chk("phase_complete", exp_q.size(), 0);
  endtask

  task automatic reset_dut();
    for (int i = 0; i < 3; i++) step(1'b1);
    exp_q.delete();
    model_last = NCH - 1;
  endtask

  initial begin
    int base;
    int n;
    // Channel 2 alone, 6 words: full burst, gap, truncated burst
    load(2, 6);
    ready_mode = 0;
    reset_dut();
    run_phase(100);

    // All channels 8 words: order 0,1,2,3,0,1,2,3
    reset_dut();
    for (int c = 0; c < NCH; c++) load(c, 8);
    run_phase(200);

    // Channel 1 with ready toggling 1,0,0,1
    reset_dut();
    load(1, 6);
    ready_mode = 2;
    run_phase(200);

    // Reset after the second word of a channel-3 burst
    ready_mode = 0;
    reset_dut();
    load(3, 6);
    build_expect();
    base = xfer_cnt;
    n    = 0;
    while (xfer_cnt < base + 2 && n < 50) begin
      step(1'b0);
      n++;
    end
    chk("two_words_before_rst", xfer_cnt - base, 2);
    step(1'b1);
    exp_q.delete();
    model_last = NCH - 1;
    load(0, 3);
    step(1'b1);
    step(1'b1);
    chk("ch3_words_left", fifo[3].size(), 4);
    run_phase(200);

    // Channels 0 and 2 pending, only 2 half full, last_chn = 3
    reset_dut();
    load(0, 2);
    load(2, 5);
    run_phase(200);

    // Randomized fill levels and backpressure
    ready_mode = 1;
    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < NCH; c++) load(c, $urandom_range(0, 9));
      run_phase(1000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
